// File: rtl/filter_multi.sv
// filter_multi: vectored input conditioner with synchroniser, rise/fall confirmation and edge strobes
// Ports: clk (rising edge), aclr (async active-high reset), in[CHANNELS] raw inputs,
//        en sample enable, rise_len/fall_len confirmation lengths (0 acts as 1),
//        out filtered levels, rise_p/fall_p one-cycle edge strobes, change = OR of all strobes.
module filter_multi #(
    parameter int       CHANNELS    = 8,
    parameter int       CNT_WIDTH   = 4,
    parameter int       SYNC_STAGES = 2,
    parameter logic     RESET_OUT   = 1'b1
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic [CHANNELS-1:0]  in,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] rise_len,
    input  logic [CNT_WIDTH-1:0] fall_len,
    output logic [CHANNELS-1:0]  out,
    output logic [CHANNELS-1:0]  rise_p,
    output logic [CHANNELS-1:0]  fall_p,
    output logic                 change
);
    localparam logic [CNT_WIDTH:0] ONE = 1;
    logic [CHANNELS-1:0] s;
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
            always_comb begin
                sync_d[0] = in;
                for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
            end
            always_ff @(posedge clk or posedge aclr) begin
                if (aclr) sync_q <= {(SYNC_STAGES*CHANNELS){RESET_OUT}};
                else      sync_q <= sync_d;
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate
    logic [CHANNELS-1:0]                out_q, out_d, rise_q, rise_d, fall_q, fall_d;
    logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0][CNT_WIDTH:0]   thr, nxt;
    logic                               change_q, change_d;
    // Counts are compared one bit wider so cnt+1 can never wrap against the threshold.
    always_comb begin
        out_d  = out_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        thr    = '0;
        nxt    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            thr[i] = {1'b0, out_q[i] ? fall_len : rise_len};
            thr[i] = (thr[i] == '0) ? ONE : thr[i];
            nxt[i] = {1'b0, cnt_q[i]} + ONE;
            if (en) begin
                if (s[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (nxt[i] >= thr[i]) begin
                    out_d[i]  = ~out_q[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = ~out_q[i];
                    fall_d[i] = out_q[i];
                end else begin
                    cnt_d[i] = nxt[i][CNT_WIDTH-1:0];
                end
            end
        end
        change_d = |{rise_d, fall_d};
    end
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            out_q    <= {CHANNELS{RESET_OUT}};
            cnt_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end
    assign out    = out_q;
    assign rise_p = rise_q;
    assign fall_p = fall_q;
    assign change = change_q;
endmodule

// File: tb/tb_filter_multi.sv
// tb_filter_multi: directed bench for filter_multi with a 2-stage and an unsynchronised instance
module tb_filter_multi;
    logic       clk = 1'b0;
    logic       aclr = 1'b0;
    logic [7:0] in = '0;
    logic       en = 1'b1;
    logic [3:0] rise_len = 4'd1;
    logic [3:0] fall_len = 4'd1;
    logic [7:0] out, rise_p, fall_p, out0, rise0, fall0;
    logic       change, chg0;
    int         vec = 0;
    int         err = 0;

    filter_multi #(.CHANNELS(8), .CNT_WIDTH(4), .SYNC_STAGES(2), .RESET_OUT(1'b1)) u_dut (
        .clk(clk), .aclr(aclr), .in(in), .en(en), .rise_len(rise_len), .fall_len(fall_len),
        .out(out), .rise_p(rise_p), .fall_p(fall_p), .change(change)
    );
    filter_multi #(.CHANNELS(8), .CNT_WIDTH(4), .SYNC_STAGES(0), .RESET_OUT(1'b1)) u_dut0 (
        .clk(clk), .aclr(aclr), .in(in), .en(en), .rise_len(rise_len), .fall_len(fall_len),
        .out(out0), .rise_p(rise0), .fall_p(fall0), .change(chg0)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        aclr = 1'b1;
        #2;
        aclr = 1'b0;
    endtask

    task automatic init(input logic [7:0] v);
        rise_len = 4'd1;
        fall_len = 4'd1;
        en = 1'b1;
        in = v;
        step(1);
        pulse_reset();
        step(6);
    endtask

    task automatic test_reset();
        in = 8'h00;
        en = 1'b1;
        rise_len = 4'd3;
        fall_len = 4'd3;
        step(1);
        aclr = 1'b1;
        step(2);
        aclr = 1'b0;
        vec++; if (out !== 8'hFF) begin err++; $display("FAIL reset_out got %h want ff", out); end
        vec++; if ({rise_p, fall_p, change} !== 17'h0) begin err++; $display("FAIL reset_strobes got %h/%h/%b want 0", rise_p, fall_p, change); end
        step(4);
        vec++; if (out !== 8'hFF) begin err++; $display("FAIL reset_hold_e4 got %h want ff", out); end
        vec++; if (fall_p !== 8'h00) begin err++; $display("FAIL reset_nofall_e4 got %h want 00", fall_p); end
        step(1);
        vec++; if (out !== 8'h00) begin err++; $display("FAIL reset_drop_e5 got %h want 00", out); end
        vec++; if (fall_p !== 8'hFF || change !== 1'b1) begin err++; $display("FAIL reset_fallp_e5 got %h/%b want ff/1", fall_p, change); end
        step(1);
        vec++; if (fall_p !== 8'h00 || change !== 1'b0) begin err++; $display("FAIL reset_fallp_e6 got %h/%b want 00/0", fall_p, change); end
    endtask

    task automatic test_glitch();
        logic [7:0] seen;
        init(8'h00);
        rise_len = 4'd4;
        seen = '0;
        in = 8'h01;
        step(3);
        seen |= rise_p | fall_p;
        in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            step(1);
            seen |= rise_p | fall_p;
        end
        vec++; if (out !== 8'h00) begin err++; $display("FAIL glitch_out got %h want 00", out); end
        vec++; if (seen !== 8'h00) begin err++; $display("FAIL glitch_strobe got %h want 00", seen); end
        in = 8'h01;
        step(5);
        vec++; if (out !== 8'h00) begin err++; $display("FAIL glitch_hold_e5 got %h want 00", out); end
        step(1);
        vec++; if (out !== 8'h01 || rise_p !== 8'h01) begin err++; $display("FAIL glitch_rise_e6 got %h/%h want 01/01", out, rise_p); end
    endtask

    task automatic test_asym();
        init(8'h00);
        rise_len = 4'd1;
        fall_len = 4'd15;
        in = 8'h01;
        step(1);
        vec++; if (out0 !== 8'h01 || rise0 !== 8'h01) begin err++; $display("FAIL asym_rise got %h/%h want 01/01", out0, rise0); end
        in = 8'h00;
        step(14);
        vec++; if (out0 !== 8'h01) begin err++; $display("FAIL asym_hold14 got %h want 01", out0); end
        step(1);
        vec++; if (out0 !== 8'h00 || fall0 !== 8'h01) begin err++; $display("FAIL asym_fall15 got %h/%h want 00/01", out0, fall0); end
        in = 8'h01;
        step(1);
        in = 8'h00;
        step(10);
        in = 8'h01;
        step(1);
        in = 8'h00;
        step(14);
        vec++; if (out0 !== 8'h01) begin err++; $display("FAIL asym_restart_hold got %h want 01", out0); end
        step(1);
        vec++; if (out0 !== 8'h00) begin err++; $display("FAIL asym_restart_fall got %h want 00", out0); end
    endtask

    task automatic test_enable();
        logic [7:0] seen;
        init(8'h00);
        rise_len = 4'd2;
        seen = '0;
        in = 8'h01;
        for (int k = 1; k <= 9; k++) begin
            en = (k % 4 == 0);
            step(1);
            if (k % 4 != 0) seen |= rise_p | fall_p | {7'd0, change};
            if (k == 4) begin
                vec++; if (out !== 8'h00) begin err++; $display("FAIL en_first got %h want 00", out); end
            end
            if (k == 8) begin
                vec++; if (out !== 8'h01 || rise_p !== 8'h01) begin err++; $display("FAIL en_second got %h/%h want 01/01", out, rise_p); end
            end
        end
        vec++; if (seen !== 8'h00) begin err++; $display("FAIL en_idle_strobe got %h want 00", seen); end
        en = 1'b1;
    endtask

    task automatic test_len_change();
        init(8'hFF);
        fall_len = 4'd10;
        in = 8'h00;
        step(5);
        vec++; if (out0 !== 8'hFF) begin err++; $display("FAIL len_hold got %h want ff", out0); end
        fall_len = 4'd3;
        step(1);
        vec++; if (out0 !== 8'h00 || fall0 !== 8'hFF) begin err++; $display("FAIL len_toggle got %h/%h want 00/ff", out0, fall0); end
        init(8'hFF);
        fall_len = 4'd10;
        in = 8'h00;
        step(5);
        pulse_reset();
        vec++; if (out0 !== 8'hFF || out !== 8'hFF) begin err++; $display("FAIL midreset_out got %h/%h want ff/ff", out0, out); end
        step(9);
        vec++; if (out0 !== 8'hFF) begin err++; $display("FAIL midreset_hold got %h want ff", out0); end
        step(1);
        vec++; if (out0 !== 8'h00) begin err++; $display("FAIL midreset_fall got %h want 00", out0); end
    endtask

    task automatic test_multi();
        logic [7:0] seen;
        init(8'h00);
        in = 8'hFF;
        step(1);
        vec++; if (out0 !== 8'hFF || rise0 !== 8'hFF || chg0 !== 1'b1) begin err++; $display("FAIL multi_rise got %h/%h/%b want ff/ff/1", out0, rise0, chg0); end
        step(1);
        vec++; if (rise0 !== 8'h00 || chg0 !== 1'b0) begin err++; $display("FAIL multi_once got %h/%b want 00/0", rise0, chg0); end
        init(8'h00);
        rise_len = 4'd2;
        fall_len = 4'd2;
        seen = '0;
        for (int k = 0; k < 6; k++) begin
            in = (k % 2 == 0) ? 8'h55 : 8'hAA;
            step(1);
            seen |= rise0 | fall0;
        end
        vec++; if (out0 !== 8'h00 || seen !== 8'h00) begin err++; $display("FAIL multi_alt got %h/%h want 00/00", out0, seen); end
        in = 8'h55;
        step(2);
        vec++; if (out0 !== 8'h55) begin err++; $display("FAIL multi_55 got %h want 55", out0); end
        in = 8'hAA;
        step(2);
        vec++; if (out0 !== 8'hAA || rise0 !== 8'hAA || fall0 !== 8'h55) begin err++; $display("FAIL multi_aa got %h/%h/%h want aa/aa/55", out0, rise0, fall0); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_asym();
        test_enable();
        test_len_change();
        test_multi();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/filter_multi.md
# filter_multi

Multi-channel digital input conditioner: a parametrised successor to the single-channel stretch filter. Each channel has an optional input synchroniser, independent run-time rise and fall confirmation lengths, a sample-enable for slow-rate filtering, and one-cycle edge strobes. It sits between raw command/discrete inputs and the decoding logic, replacing per-bit filter instances with one vectored block.

## Interface
- CHANNELS, 8: number of independent channels (1..32).
- CNT_WIDTH, 4: width of the confirmation counters and length inputs; max length 2^CNT_WIDTH-1.
- SYNC_STAGES, 2: flip-flops in the per-channel input synchroniser (0..3). 0 means `in` feeds the filter directly.
- RESET_OUT, 1'b1: value of every `out` bit after reset.

- clk  in  1  clock, rising edge.
- aclr  in  1  reset, asynchronous, active-high.
- in  in  CHANNELS  raw inputs.
- en  in  1  sample enable. Filter state advances only when 1.
- rise_len  in  CNT_WIDTH  consecutive enabled samples of 1 needed to raise an output. 0 is treated as 1.
- fall_len  in  CNT_WIDTH  consecutive enabled samples of 0 needed to drop an output. 0 is treated as 1.
- out  out  CHANNELS  filtered levels, registered.
- rise_p  out  CHANNELS  one-cycle strobe in the cycle `out[i]` becomes 1.
- fall_p  out  CHANNELS  one-cycle strobe in the cycle `out[i]` becomes 0.
- change  out  1  registered OR of all `rise_p` and `fall_p` bits, in the same cycle as them.

## Operation
- **Synchroniser:**
  - Shifts on every clk edge, regardless of `en`.
  - The sampled value `s[i]` is the last stage output, or `in[i]` when SYNC_STAGES=0.
  - All stages reset to RESET_OUT.
- **Per-channel state:** `out[i]` plus counter `cnt[i]` (CNT_WIDTH bits).
- **Threshold:** `thr = out[i] ? fall_len : rise_len`, with 0 mapped to 1.
- **On an edge with en=1:**
  - If `s[i] == out[i]`, then `cnt[i] <= 0`. Any partial deviation is discarded, so glitches shorter than `thr` samples never reach `out`.
  - Otherwise, if `cnt[i]+1 >= thr`, then `out[i]` toggles, `cnt[i] <= 0`, and the matching `rise_p`/`fall_p` bit is 1 for that cycle.
  - Otherwise, `cnt[i] <= cnt[i]+1`.
- **On an edge with en=0:** `out` and `cnt` hold; `rise_p`, `fall_p` and `change` are 0.
- **Counter range:** `cnt` never exceeds `thr-1`, so it cannot wrap. The comparison uses CNT_WIDTH+1 bits.
- **Length change mid-count:** takes effect at the next enabled sample.
  - If the new `thr` is at or below `cnt+1`, the output toggles on that sample.
  - The count is not restarted.
- **Channel independence:** channels are fully independent; simultaneous toggles on several channels are all reported.
- **Reset state:** `out`=all RESET_OUT, `cnt`=0, synchroniser=all RESET_OUT, strobes=0, `change`=0.
  - Reset mid-count discards all progress.
  - After `aclr` falls, the first rising edge processes normally.

## Timing
- **Latency:** with en held 1, a clean level change on `in[i]` appears on `out[i]` on the (SYNC_STAGES+thr)-th rising edge. Edge 1 is the first edge that registers the new `in` value.
- **Example:** SYNC_STAGES=2 and rise_len=3 give out=1 on edge 5.
- **Strobes:** `rise_p`/`fall_p` are asserted in the same cycle `out` changes. They are registered and high for exactly one clk.
- **Sample enable:** with `en` pulsed every K cycles, the filter latency is `thr` enabled edges. Synchroniser latency stays SYNC_STAGES clk edges.
- **Outputs:** all outputs are driven from flip-flops, with no combinational path from `in`.

## Test plan
- **Reset state:** reset with RESET_OUT=1 and in=0, SYNC=2, fall_len=3 -> out=all 1 after `aclr` falls.
  - out[i] drops on edge 5 with a single fall_p pulse and change=1.
- **Glitch rejection:** rise_len=4, in[0] high for 3 edges, then low -> out[0] stays 0, with no strobes.
  - Holding in[0] high for 4 edges -> out[0]=1 on edge SYNC_STAGES+4.
- **Asymmetric lengths:** rise_len=1, fall_len=15, SYNC=0 -> rise on edge 1.
  - After in drops, out stays 1 for 14 edges and falls on edge 15.
  - A single-cycle 1 during the low run restarts the count.
- **Sample enable:** en high every 4th cycle, rise_len=2 -> out rises on the 2nd enabled edge.
  - No strobes are generated while en=0.
- **Length change and reset mid-count:**
  - cnt=5, fall_len lowered from 10 to 3 -> toggle on the next enabled mismatching sample.
  - Separately, asserting aclr at cnt=5 -> out returns to RESET_OUT and the count restarts from 0.
- **Multi-channel:** all CHANNELS toggled in the same cycle -> all strobes pulse together for one cycle with change=1.
  - Adjacent channels with opposite patterns do not interact.
